// File: rtl/sort_engine_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sort_engine_ctrl                                            |
// | Purpose  : Frame sequencer for the gnome sort engine. Takes one frame  |
// |            on a valid/ready input stream, clears and loads the engine, |
// |            starts the sort, waits for done, then drains the sorted     |
// |            words in ascending order onto a valid/ready output stream   |
// |            with a last marker.                                         |
// | Ports    : clk_i, rst_n_i (async, active-low)                          |
// |            s_valid_i/s_data_i/s_last_i/s_ready_o  input stream         |
// |            m_valid_o/m_data_o/m_last_o/m_ready_i  output stream        |
// |            eng_srst_o/eng_run_o/eng_wr_req_o/eng_wr_data_o/            |
// |            eng_rd_req_o/eng_rd_data_i/eng_done_i  engine control       |
// |            busy_o, overflow_o, timeout_o          status               |
// | Options  : SORT_CTRL_TIMEOUT_EN enables the WAIT-state watchdog.       |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module sort_engine_ctrl #(
  parameter int AWIDTH         = 5,
  parameter int DWIDTH         = 8,
  parameter int TIMEOUT_CYCLES = 4 * (2**AWIDTH) * (2**AWIDTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              s_valid_i,
  input  logic [DWIDTH-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              eng_srst_o,
  output logic              eng_run_o,
  output logic              eng_wr_req_o,
  output logic [DWIDTH-1:0] eng_wr_data_o,
  output logic              eng_rd_req_o,
  input  logic [DWIDTH-1:0] eng_rd_data_i,
  input  logic              eng_done_i,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              timeout_o
);

  localparam int              c_cw    = AWIDTH + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(2**AWIDTH);
  localparam logic [c_cw-1:0] c_one   = c_cw'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_WAIT  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [c_cw-1:0]   r_cnt;           // words written into the engine
  logic [c_cw-1:0]   r_issued;        // read requests issued in DRAIN
  logic              r_drop;          // at least one word was discarded
  logic              r_inflight;      // read issued last cycle, data arrives now
  logic              r_inflight_last; // that read targets word cnt-1
  logic [1:0]        r_occ;           // output FIFO occupancy (0..2)
  logic              r_wptr;
  logic              r_rptr;
  logic [DWIDTH-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;

  logic              w_full;
  logic              w_pop;
  logic [2:0]        w_level;
  logic              w_rd_req;
  logic              w_wd_hit;

  assign w_full = (r_cnt == c_depth);
  assign w_pop  = (r_occ != 2'd0) && m_ready_i;

  // Occupancy the FIFO will have once the in-flight word lands and the
  // current pop retires; a new read is only safe if that leaves a free slot.
  assign w_level  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_req = (r_state == S_DRAIN) && (r_issued < r_cnt) && (w_level < 3'd2);

  assign m_valid_o = (r_occ != 2'd0);
  assign m_data_o  = m_valid_o ? r_fifo_data[r_rptr] : '0;
  assign m_last_o  = m_valid_o & r_fifo_last[r_rptr];

`ifdef SORT_CTRL_TIMEOUT_EN
  localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wd_w-1:0] r_wd;

  // Counts cycles spent in WAIT; zero in every other state, so it starts
  // from 0 on each entry to WAIT.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd <= r_wd + c_wd_w'(1);
    end else begin
      r_wd <= '0;
    end
  end

  assign w_wd_hit = (r_wd == c_wd_w'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout;

  assign w_wd_hit         = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    s_ready_o     = 1'b0;
    eng_srst_o    = 1'b0;
    eng_run_o     = 1'b0;
    eng_wr_req_o  = 1'b0;
    eng_wr_data_o = '0;
    eng_rd_req_o  = 1'b0;
    overflow_o    = 1'b0;
    timeout_o     = 1'b0;
    busy_o        = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        // The pending word is not consumed here; LOAD accepts it.
        if (s_valid_i) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        eng_srst_o  = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          if (!w_full) begin
            eng_wr_req_o  = 1'b1;
            eng_wr_data_o = s_data_i;
          end
          if (s_last_i) begin
            // Includes the case where the last word itself is the one dropped.
            overflow_o  = r_drop | w_full;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        eng_run_o   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done_i) begin
          w_state_nxt = S_DRAIN;
        end else if (w_wd_hit) begin
          timeout_o   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        eng_rd_req_o = w_rd_req;
        if (w_pop && r_fifo_last[r_rptr]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt           <= '0;
      r_issued        <= '0;
      r_drop          <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_occ           <= 2'd0;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last     <= 2'b00;
    end else if (r_state == S_CLEAR) begin
      r_cnt           <= '0;
      r_issued        <= '0;
      r_drop          <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_occ           <= 2'd0;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
    end else begin
      if ((r_state == S_LOAD) && s_valid_i) begin
        if (!w_full) begin
          r_cnt <= r_cnt + c_one;
        end else begin
          r_drop <= 1'b1;
        end
      end

      r_inflight      <= w_rd_req;
      r_inflight_last <= (r_issued == r_cnt - c_one);
      if (w_rd_req) begin
        r_issued <= r_issued + c_one;
      end

      // Engine read data is valid the cycle after its request.
      if (r_inflight) begin
        r_fifo_data[r_wptr] <= eng_rd_data_i;
        r_fifo_last[r_wptr] <= r_inflight_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_engine_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_sort_engine_ctrl                                         |
// | Purpose  : Self-checking bench for sort_engine_ctrl with a behavioural |
// |            engine model and an output scoreboard.                      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_sort_engine_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 2**AW;
`ifdef SORT_CTRL_TIMEOUT_EN
  localparam int TO    = 100;
`else
  localparam int TO    = 4 * DEPTH * DEPTH;
`endif

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          s_valid_i;
  logic [DW-1:0] s_data_i;
  logic          s_last_i;
  logic          s_ready_o;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          m_ready_i;
  logic          eng_srst_o;
  logic          eng_run_o;
  logic          eng_wr_req_o;
  logic [DW-1:0] eng_wr_data_o;
  logic          eng_rd_req_o;
  logic [DW-1:0] eng_rd_data_i = '0;
  logic          eng_done_i = 1'b0;
  logic          busy_o;
  logic          overflow_o;
  logic          timeout_o;

  always #5 clk = ~clk;

  sort_engine_ctrl #(
    .AWIDTH         (AW),
    .DWIDTH         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_last_i      (s_last_i),
    .s_ready_o     (s_ready_o),
    .m_valid_o     (m_valid_o),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o),
    .m_ready_i     (m_ready_i),
    .eng_srst_o    (eng_srst_o),
    .eng_run_o     (eng_run_o),
    .eng_wr_req_o  (eng_wr_req_o),
    .eng_wr_data_o (eng_wr_data_o),
    .eng_rd_req_o  (eng_rd_req_o),
    .eng_rd_data_i (eng_rd_data_i),
    .eng_done_i    (eng_done_i),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o),
    .timeout_o     (timeout_o)
  );

  logic [25:0] w_outs;
  assign w_outs = {s_ready_o, m_valid_o, m_data_o, m_last_o, eng_srst_o, eng_run_o,
                   eng_wr_req_o, eng_wr_data_o, eng_rd_req_o, busy_o, overflow_o,
                   timeout_o};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual %0h required %0h", tag, act, exp);
    end
  endtask

  // ---------------- engine model ----------------
  logic [DW-1:0] eng_q[$];
  int            rd_ptr    = 0;
  bit            sorting   = 1'b0;
  int            sort_cnt  = 0;
  bit            hold_done = 1'b0;

  always @(posedge clk) begin
    if (eng_srst_o) begin
      eng_q.delete();
      eng_done_i <= 1'b0;
      rd_ptr     <= 0;
      sorting    <= 1'b0;
    end else begin
      if (eng_wr_req_o) eng_q.push_back(eng_wr_data_o);
      if (eng_run_o) begin
        eng_q.sort();
        rd_ptr   <= 0;
        sorting  <= 1'b1;
        sort_cnt <= 2 + eng_q.size();
      end else if (sorting && !hold_done) begin
        if (sort_cnt == 0) begin
          eng_done_i <= 1'b1;
          sorting    <= 1'b0;
        end else begin
          sort_cnt <= sort_cnt - 1;
        end
      end
      if (eng_rd_req_o) begin
        eng_rd_data_i <= (rd_ptr < eng_q.size()) ? eng_q[rd_ptr] : '0;
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  // ---------------- output ready driver ----------------
  bit rand_rdy = 1'b0;

  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [DW:0] exp_q[$];
  int          cyc     = 0;
  int          run_cnt = 0;
  int          ovf_cnt = 0;
  int          to_cnt  = 0;
  int          run_cyc = 0;
  int          to_cyc  = 0;
  int          n_out   = 0;
  bit          hold_pend = 1'b0;
  logic [DW:0] hold_val;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n_i) begin
      hold_pend = 1'b0;
    end else begin
      if (eng_run_o) begin run_cnt++; run_cyc = cyc; end
      if (overflow_o) ovf_cnt++;
      if (timeout_o) begin to_cnt++; to_cyc = cyc; end
      if (hold_pend)
        check_eq("hold_stable", {m_valid_o, m_last_o, m_data_o}, {1'b1, hold_val});
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("out_pending", exp_q.size(), 1);
        end else begin
          check_eq("out_word", {m_last_o, m_data_o}, exp_q.pop_front());
        end
        n_out++;
      end
      hold_pend = m_valid_o && !m_ready_i;
      hold_val  = {m_last_o, m_data_o};
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] tx_q[$];

  task automatic send_frame(input bit expect_out);
    logic [DW-1:0] sq[$];
    int            n;
    int            guard;
    bit            ovf_seen;
    n = tx_q.size();
    for (int i = 0; i < n && i < DEPTH; i++) sq.push_back(tx_q[i]);
    sq.sort();
    if (expect_out)
      for (int i = 0; i < sq.size(); i++) exp_q.push_back({1'(i == sq.size() - 1), sq[i]});
    ovf_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = tx_q[i];
      s_last_i  = (i == n - 1);
      guard     = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!s_ready_o && guard < 50);
      if (!s_ready_o) check_eq("s_ready_wait", s_ready_o, 1);
      if (s_last_i) ovf_seen = overflow_o;
      @(posedge clk);
      #1;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    check_eq("ovf_on_last", ovf_seen, (n > DEPTH));
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((busy_o || exp_q.size() != 0) && guard < 3000);
    check_eq("busy_after", busy_o, 0);
    check_eq("exp_left", exp_q.size(), 0);
  endtask

  int r0;
  int o0;
  int guard;

  initial begin
    rst_n_i   = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_last_i  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", w_outs, 0);
    @(posedge clk);
    #3 rst_n_i = 1'b1;
    repeat (2) @(negedge clk);

    // Basic four-word frame.
    tx_q = '{8'd5, 8'd3, 8'd9, 8'd1};
    send_frame(1'b1);
    wait_idle();

    // Single-word frame.
    r0   = run_cnt;
    tx_q = '{8'h7F};
    send_frame(1'b1);
    wait_idle();
    check_eq("run_pulses", run_cnt - r0, 1);

    // 34-word descending frame overflows a 32-word engine.
    o0 = ovf_cnt;
    tx_q.delete();
    for (int v = 33; v >= 0; v--) tx_q.push_back(DW'(v));
    send_frame(1'b1);
    wait_idle();
    check_eq("ovf_pulses", ovf_cnt - o0, 1);

    // Random frame with random downstream backpressure.
    rand_rdy = 1'b1;
    tx_q.delete();
    for (int i = 0; i < 8; i++) tx_q.push_back(DW'($urandom_range(0, 255)));
    send_frame(1'b1);
    wait_idle();
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of DRAIN, then a fresh frame.
    tx_q.delete();
    for (int i = 0; i < 8; i++) tx_q.push_back(DW'(40 - i));
    r0 = n_out;
    send_frame(1'b1);
    guard = 0;
    while (n_out < r0 + 2 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_started", n_out >= r0 + 2, 1);
    @(posedge clk);
    #2 rst_n_i = 1'b0;
    #1 check_eq("mid_reset_outs", w_outs, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_eq("mid_reset_hold", w_outs, 0);
    @(posedge clk);
    #3 rst_n_i = 1'b1;
    tx_q = '{8'd2, 8'd1};
    send_frame(1'b1);
    wait_idle();

`ifdef SORT_CTRL_TIMEOUT_EN
    // Engine never reports done: watchdog aborts the frame.
    hold_done = 1'b1;
    r0 = n_out;
    o0 = to_cnt;
    tx_q = '{8'd7, 8'd6, 8'd5};
    send_frame(1'b0);
    guard = 0;
    while (to_cnt == o0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_eq("to_pulses", to_cnt - o0, 1);
    check_eq("to_latency", to_cyc - run_cyc, 101);
    check_eq("to_no_output", n_out - r0, 0);
    hold_done = 1'b0;
    wait_idle();
    tx_q = '{8'd30, 8'd10, 8'd20};
    send_frame(1'b1);
    wait_idle();
`else
    check_eq("timeout_quiet", to_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sort_engine_ctrl.md
# sort_engine_ctrl

Frame-level sequencer for the gnome sort engine. It accepts one frame of words on a valid/ready input stream, clears the engine, loads it, starts the sort and waits for completion. It then drains the sorted words, in ascending order, onto a valid/ready output stream with a last marker. It sits between the streaming fabric and the engine and owns every engine control strobe.

## Interface
- AWIDTH, 5: engine address width; frame capacity DEPTH = 2**AWIDTH words.
- DWIDTH, 8: data word width.
- TIMEOUT_CYCLES, 4*DEPTH*DEPTH: sort watchdog limit; used only with SORT_CTRL_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock. One clock; reset is asynchronous and active-low.
- rst_n_i  in  1  asynchronous active-low reset.
- s_valid_i  in  1  input word valid.
- s_data_i  in  DWIDTH  input word.
- s_last_i  in  1  last word of frame.
- s_ready_o  out  1  input word accepted when high together with s_valid_i.
- m_valid_o  out  1  output word valid.
- m_data_o  out  DWIDTH  sorted word.
- m_last_o  out  1  last sorted word of frame.
- m_ready_i  in  1  downstream accept.
- eng_srst_o  out  1  engine sync clear.
- eng_run_o  out  1  engine start strobe.
- eng_wr_req_o  out  1  engine write.
- eng_wr_data_o  out  DWIDTH  engine write data.
- eng_rd_req_o  out  1  engine read.
- eng_rd_data_i  in  DWIDTH  engine read data, valid 1 cycle after eng_rd_req_o.
- eng_done_i  in  1  engine sort done (sticky until eng_srst_o).
- busy_o  out  1  high in every state except IDLE.
- overflow_o  out  1  1-cycle pulse: frame exceeded DEPTH and was truncated.
- timeout_o  out  1  1-cycle pulse: watchdog abort (0 without macro).

## Operation
- States: IDLE, CLEAR, LOAD, RUN, WAIT, DRAIN.
- IDLE: s_ready_o=0. When s_valid_i=1, go to CLEAR. The word stays pending.
- CLEAR: eng_srst_o=1 for exactly 1 cycle. Word counter cnt (AWIDTH+1 bits) is zeroed. Go to LOAD.
- LOAD: s_ready_o=1. For each accepted word:
  - If cnt<DEPTH: eng_wr_req_o=1, eng_wr_data_o=s_data_i (combinational, same cycle), cnt++.
  - If cnt==DEPTH: the word is dropped and a drop flag is set.
  - Accepted word with s_last_i=1: go to RUN. If the drop flag is set, pulse overflow_o in that same cycle.
- RUN: eng_run_o=1 for exactly 1 cycle. Go to WAIT.
- WAIT: when eng_done_i=1, go to DRAIN on the next edge.
- DRAIN:
  - Issue eng_rd_req_o while issued<cnt and (fifo_occ + inflight − pop_this_cycle) < 2.
  - The returned eng_rd_data_i is pushed into a 2-entry output FIFO one cycle after the request.
  - m_valid_o = FIFO non-empty. m_last_o=1 on the word whose index is cnt−1.
  - When the last word is accepted (m_valid_o & m_ready_i & m_last_o), go to IDLE.
- eng_rd_req_o is never asserted outside DRAIN. eng_wr_req_o is never asserted outside LOAD.
- A frame is at least 1 word, because s_last_i travels with a word. A 1-word frame still passes through RUN/WAIT; the engine reports done with no swaps.

## Timing
- Reset values: all outputs 0. State IDLE; cnt, issued, FIFO occupancy and drop flag are 0.
- Reset mid-frame aborts immediately. Partial output is lost, and the engine is not touched until the next frame's CLEAR.
- Minimum overhead per frame: IDLE→CLEAR 1 cycle, CLEAR 1, RUN 1, then WAIT ≥1, then DRAIN.
- First m_valid_o comes 2 cycles after entering DRAIN (request cycle + RAM latency). Sustained rate is 1 word/cycle while m_ready_i=1.
- Backpressure: m_data_o and m_last_o are held stable while m_valid_o=1 and m_ready_i=0. No word is lost or duplicated, and the FIFO never overflows under arbitrary m_ready_i patterns.
- s_ready_o low in IDLE/CLEAR creates a 2-cycle input stall at the start of each frame.
- Simultaneous s_last_i and overflow: the last word is dropped, overflow_o pulses, and the state still advances to RUN.

## Configuration
- SORT_CTRL_TIMEOUT_EN defined:
  - A counter starts at 0 on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES with eng_done_i=0: timeout_o pulses 1 cycle, the frame is discarded with no output, and the state goes to IDLE.
  - The next frame's CLEAR resets the engine.
- Not defined: no counter is built, timeout_o is tied 0, and WAIT waits indefinitely.

## Test plan
- Frame 5,3,9,1 (last on 1), m_ready_i=1 → m_data 1,3,5,9; m_last_o only on 9; busy_o back to 0 after it.
- Single word 0x7F → output 0x7F with m_last_o=1; eng_run_o pulsed once.
- AWIDTH=5, 34-word descending frame 33..0 → overflow_o pulses once on the last input; output is the first 32 words sorted, 2..33, with m_last_o on 33.
- 8-word random frame with m_ready_i toggling randomly → output equals the sorted input, with no drops or duplicates, and data held stable during stalls.
- rst_n_i asserted mid-DRAIN, then frame 2,1 → all outputs 0 during reset; output 1,2 with m_last_o on 2.
- With SORT_CTRL_TIMEOUT_EN and a model holding eng_done_i=0, TIMEOUT_CYCLES=100 → timeout_o pulses 100 cycles after entering WAIT, m_valid_o stays 0, and the next frame sorts correctly.
